// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the instruction/data memory port arbiter:
// state encodings, port identifiers and the latched request record.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY_I  = 2'b01,
        ST_BUSY_D  = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    function automatic port_t other_port(input port_t p);
        return (p == PORT_I) ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_next_state.sv
// Combinational next-state and grant selection for the memory port arbiter.
// A data request with both rd and wr set is never granted.
module mem_port_arbiter_next_state
    import mem_port_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  state_t state,
    input  port_t  last_grant,
    input  logic   i_rd,
    input  logic   d_rd,
    input  logic   d_wr,
    input  logic   m_done,
    output state_t next_state,
    output logic   grant_valid,
    output port_t  grant_port,
    output logic   illegal_op,
    output logic   illegal_state
);

    logic d_valid;

    assign d_valid    = d_rd ^ d_wr;
    assign illegal_op = d_rd & d_wr;

    always_comb begin
        next_state    = ST_IDLE;
        grant_valid   = 1'b0;
        grant_port    = PORT_I;
        illegal_state = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_rd && d_valid) begin
                    grant_valid = 1'b1;
                    grant_port  = FIXED_PRIO ? PORT_D : other_port(last_grant);
                end else if (i_rd) begin
                    grant_valid = 1'b1;
                    grant_port  = PORT_I;
                end else if (d_valid) begin
                    grant_valid = 1'b1;
                    grant_port  = PORT_D;
                end
                if (grant_valid) begin
                    next_state = (grant_port == PORT_D) ? ST_BUSY_D : ST_BUSY_I;
                end
            end
            ST_BUSY_I: next_state = m_done ? ST_IDLE : ST_BUSY_I;
            ST_BUSY_D: next_state = m_done ? ST_IDLE : ST_BUSY_D;
            default: begin
                illegal_state = 1'b1;
                next_state    = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared memory
// system; the granted request is latched and replayed until m_done.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data_in,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [DATA_W-1:0] m_data_out,
    input  logic              m_done,
    input  logic              m_cache_hit,
    input  logic              m_err,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data_in,
    output logic              m_rd,
    output logic              m_wr,
    output logic [DATA_W-1:0] i_data_out,
    output logic [DATA_W-1:0] d_data_out,
    output logic              i_done,
    output logic              d_done,
    output logic              i_stall,
    output logic              d_stall,
    output logic              i_cache_hit,
    output logic              d_cache_hit,
    output logic              err
);

    state_t state_q;
    state_t next_state;
    port_t  last_grant_q;
    port_t  grant_port;
    req_t   req_q;
    req_t   grant_req;
    logic   grant_valid;
    logic   illegal_op;
    logic   illegal_state;
    logic   busy_i;
    logic   busy_d;
    logic   xfer_done;

    mem_port_arbiter_next_state #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_next_state (
        .state         (state_q),
        .last_grant    (last_grant_q),
        .i_rd          (i_rd),
        .d_rd          (d_rd),
        .d_wr          (d_wr),
        .m_done        (m_done),
        .next_state    (next_state),
        .grant_valid   (grant_valid),
        .grant_port    (grant_port),
        .illegal_op    (illegal_op),
        .illegal_state (illegal_state)
    );

    // Instruction fetches are always reads with no write data.
    always_comb begin
        grant_req = '0;
        if (grant_port == PORT_D) begin
            grant_req.rd   = d_rd;
            grant_req.wr   = d_wr;
            grant_req.addr = d_addr;
            grant_req.data = d_data_in;
        end else begin
            grant_req.rd   = 1'b1;
            grant_req.addr = i_addr;
        end
    end

    assign xfer_done = ((state_q == ST_BUSY_I) || (state_q == ST_BUSY_D)) && m_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_I;
            req_q        <= '0;
        end else begin
            state_q <= next_state;
            if (grant_valid) begin
                last_grant_q <= grant_port;
                req_q        <= grant_req;
            end else if (xfer_done) begin
                req_q <= '0;
            end
        end
    end

    // Every output is forced low while reset is held so an abandoned
    // transaction can never signal completion.
    assign busy_i = !rst && (state_q == ST_BUSY_I);
    assign busy_d = !rst && (state_q == ST_BUSY_D);

    always_comb begin
        m_rd        = 1'b0;
        m_wr        = 1'b0;
        m_addr      = '0;
        m_data_in   = '0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        i_data_out  = '0;
        d_data_out  = '0;
        i_cache_hit = 1'b0;
        d_cache_hit = 1'b0;
        if (busy_i || busy_d) begin
            m_rd      = req_q.rd;
            m_wr      = req_q.wr;
            m_addr    = req_q.addr;
            m_data_in = req_q.data;
        end
        if (busy_i && m_done) begin
            i_done      = 1'b1;
            i_data_out  = m_data_out;
            i_cache_hit = m_cache_hit;
        end
        if (busy_d && m_done) begin
            d_done      = 1'b1;
            d_data_out  = m_data_out;
            d_cache_hit = m_cache_hit;
        end
    end

    assign i_stall = !rst && i_rd && !(busy_i && m_done);
    assign d_stall = !rst && (d_rd || d_wr) && !(busy_d && m_done);
    assign err     = !rst && (m_err || illegal_op || illegal_state);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter: a per-cycle stimulus/expectation
// table, then a continuous-contention sequence on round-robin and fixed-priority copies.
module tb_mem_port_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [15:0] Z = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, i_rd, d_rd, d_wr, m_done, m_cache_hit, m_err;
    logic [15:0] i_addr, d_addr, d_data_in, m_data_out;

    logic [15:0] m_addr, m_data_in, i_data_out, d_data_out;
    logic        m_rd, m_wr, i_done, d_done, i_stall, d_stall, i_cache_hit, d_cache_hit, err;

    logic [15:0] f_m_addr, f_m_data_in, f_i_data_out, f_d_data_out;
    logic        f_m_rd, f_m_wr, f_i_done, f_d_done, f_i_stall, f_d_stall;
    logic        f_i_cache_hit, f_d_cache_hit, f_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i_rd(i_rd), .d_addr(d_addr),
        .d_data_in(d_data_in), .d_rd(d_rd), .d_wr(d_wr), .m_data_out(m_data_out),
        .m_done(m_done), .m_cache_hit(m_cache_hit), .m_err(m_err),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
        .i_data_out(i_data_out), .d_data_out(d_data_out), .i_done(i_done),
        .d_done(d_done), .i_stall(i_stall), .d_stall(d_stall),
        .i_cache_hit(i_cache_hit), .d_cache_hit(d_cache_hit), .err(err)
    );

    mem_port_arbiter #(.FIXED_PRIO(1'b1)) dut_fixed (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i_rd(i_rd), .d_addr(d_addr),
        .d_data_in(d_data_in), .d_rd(d_rd), .d_wr(d_wr), .m_data_out(m_data_out),
        .m_done(m_done), .m_cache_hit(m_cache_hit), .m_err(m_err),
        .m_addr(f_m_addr), .m_data_in(f_m_data_in), .m_rd(f_m_rd), .m_wr(f_m_wr),
        .i_data_out(f_i_data_out), .d_data_out(f_d_data_out), .i_done(f_i_done),
        .d_done(f_d_done), .i_stall(f_i_stall), .d_stall(f_d_stall),
        .i_cache_hit(f_i_cache_hit), .d_cache_hit(f_d_cache_hit), .err(f_err)
    );

    typedef struct {
        string       name;
        logic        rst, i_rd;
        logic [15:0] i_addr;
        logic        d_rd, d_wr;
        logic [15:0] d_addr, d_din, m_dout;
        logic        m_done, m_hit, m_err;
        logic        x_m_rd, x_m_wr;
        logic [15:0] x_m_addr, x_m_din;
        logic        x_i_done, x_d_done;
        logic [15:0] x_i_dout, x_d_dout;
        logic        x_i_stall, x_d_stall, x_i_hit, x_d_hit, x_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(
        input string n, input logic r, input logic ir, input logic [15:0] ia,
        input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
        input logic [15:0] mo, input logic md, input logic mh, input logic me,
        input logic xr, input logic xw, input logic [15:0] xa, input logic [15:0] xd,
        input logic xid, input logic xdd, input logic [15:0] xio, input logic [15:0] xdo,
        input logic xis, input logic xds, input logic xih, input logic xdh, input logic xe);
        vec_t v;
        v.name = n; v.rst = r; v.i_rd = ir; v.i_addr = ia; v.d_rd = dr; v.d_wr = dw;
        v.d_addr = da; v.d_din = dd; v.m_dout = mo; v.m_done = md; v.m_hit = mh; v.m_err = me;
        v.x_m_rd = xr; v.x_m_wr = xw; v.x_m_addr = xa; v.x_m_din = xd;
        v.x_i_done = xid; v.x_d_done = xdd; v.x_i_dout = xio; v.x_d_dout = xdo;
        v.x_i_stall = xis; v.x_d_stall = xds; v.x_i_hit = xih; v.x_d_hit = xdh; v.x_err = xe;
        vecs.push_back(v);
    endfunction

    task automatic chk1(input string nm, input string fld, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%b required=%b", nm, fld, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ir, input logic [15:0] ia, input logic dr,
                         input logic dw, input logic [15:0] da, input logic [15:0] dd,
                         input logic [15:0] mo, input logic md, input logic mh, input logic me);
        rst = r; i_rd = ir; i_addr = ia; d_rd = dr; d_wr = dw; d_addr = da;
        d_data_in = dd; m_data_out = mo; m_done = md; m_cache_hit = mh; m_err = me;
    endtask

    initial begin
        drive(H, L, Z, L, L, Z, Z, Z, L, L, L);

        //   name            rst i_rd i_addr    d_rd d_wr d_addr    d_din     m_dout    dn hit er | m_rd m_wr m_addr    m_din     idn ddn i_dout    d_dout    ist dst ihit dhit err
        add("rst",           H, L, Z,        L, L, Z,        Z,        Z,        L, L, L,  L, L, Z,        Z,        L, L, Z,        Z,        L, L, L, L, L);
        add("rst2",          H, L, Z,        L, L, Z,        Z,        Z,        L, L, L,  L, L, Z,        Z,        L, L, Z,        Z,        L, L, L, L, L);
        add("i_req",         L, H, 16'h0040, L, L, Z,        Z,        Z,        L, L, L,  L, L, Z,        Z,        L, L, Z,        Z,        H, L, L, L, L);
        add("i_busy1",       L, H, 16'h0040, L, L, Z,        Z,        Z,        L, L, L,  H, L, 16'h0040, Z,        L, L, Z,        Z,        H, L, L, L, L);
        add("i_busy2",       L, H, 16'h0044, L, L, Z,        Z,        Z,        L, L, L,  H, L, 16'h0040, Z,        L, L, Z,        Z,        H, L, L, L, L);
        add("i_done",        L, H, 16'h0040, L, L, Z,        Z,        16'hBEEF, H, H, L,  H, L, 16'h0040, Z,        H, L, 16'hBEEF, Z,        L, L, H, L, L);
        add("idle_mdone",    L, L, Z,        L, L, Z,        Z,        16'h1111, H, H, L,  L, L, Z,        Z,        L, L, Z,        Z,        L, L, L, L, L);
        add("rst_tie",       H, L, Z,        L, L, Z,        Z,        Z,        L, L, L,  L, L, Z,        Z,        L, L, Z,        Z,        L, L, L, L, L);
        add("tie",           L, H, 16'h0010, L, H, 16'h0020, 16'h1234, Z,        L, L, L,  L, L, Z,        Z,        L, L, Z,        Z,        H, H, L, L, L);
        add("tie_busy_d",    L, H, 16'h0010, L, H, 16'h0020, 16'h1234, Z,        L, L, L,  L, H, 16'h0020, 16'h1234, L, L, Z,        Z,        H, H, L, L, L);
        add("d_addr_change", L, H, 16'h0010, L, H, 16'h0099, 16'hFFFF, Z,        L, L, L,  L, H, 16'h0020, 16'h1234, L, L, Z,        Z,        H, H, L, L, L);
        add("d_done",        L, H, 16'h0010, L, H, 16'h0099, 16'hFFFF, 16'h5555, H, L, L,  L, H, 16'h0020, 16'h1234, L, H, Z,        16'h5555, H, L, L, L, L);
        add("bubble",        L, H, 16'h0010, L, L, Z,        Z,        Z,        L, L, L,  L, L, Z,        Z,        L, L, Z,        Z,        H, L, L, L, L);
        add("i_after_d",     L, H, 16'h0010, L, L, Z,        Z,        Z,        L, L, L,  H, L, 16'h0010, Z,        L, L, Z,        Z,        H, L, L, L, L);
        add("i_done2",       L, H, 16'h0010, L, L, Z,        Z,        16'hA5A5, H, H, L,  H, L, 16'h0010, Z,        H, L, 16'hA5A5, Z,        L, L, H, L, L);
        add("rereq_idle",    L, H, 16'h0010, L, L, Z,        Z,        Z,        L, L, L,  L, L, Z,        Z,        L, L, Z,        Z,        H, L, L, L, L);
        add("rereq_busy",    L, H, 16'h0010, L, L, Z,        Z,        Z,        L, L, L,  H, L, 16'h0010, Z,        L, L, Z,        Z,        H, L, L, L, L);
        add("m_err_done",    L, H, 16'h0010, L, L, Z,        Z,        16'h0F0F, H, L, H,  H, L, 16'h0010, Z,        H, L, 16'h0F0F, Z,        L, L, L, L, H);
        add("illegal_op",    L, L, Z,        H, H, 16'h0030, Z,        Z,        L, L, L,  L, L, Z,        Z,        L, L, Z,        Z,        L, H, L, L, H);
        add("illegal_hold",  L, L, Z,        H, H, 16'h0030, Z,        Z,        L, L, L,  L, L, Z,        Z,        L, L, Z,        Z,        L, H, L, L, H);
        add("illegal_w_i",   L, H, 16'h0050, H, H, 16'h0030, Z,        Z,        L, L, L,  L, L, Z,        Z,        L, L, Z,        Z,        H, H, L, L, H);
        add("i_granted",     L, H, 16'h0050, L, L, Z,        Z,        Z,        L, L, L,  H, L, 16'h0050, Z,        L, L, Z,        Z,        H, L, L, L, L);
        add("rst_mid",       H, H, 16'h0050, L, L, Z,        Z,        16'h2222, H, H, L,  L, L, Z,        Z,        L, L, Z,        Z,        L, L, L, L, L);
        add("post_rst",      L, L, Z,        L, L, Z,        Z,        16'h7777, H, H, L,  L, L, Z,        Z,        L, L, Z,        Z,        L, L, L, L, L);

        @(posedge clk);
        #1;
        foreach (vecs[k]) begin
            vec_t v;
            v = vecs[k];
            drive(v.rst, v.i_rd, v.i_addr, v.d_rd, v.d_wr, v.d_addr, v.d_din,
                  v.m_dout, v.m_done, v.m_hit, v.m_err);
            #2;
            chk1 (v.name, "m_rd",        m_rd,        v.x_m_rd);
            chk1 (v.name, "m_wr",        m_wr,        v.x_m_wr);
            chk16(v.name, "m_addr",      m_addr,      v.x_m_addr);
            chk16(v.name, "m_data_in",   m_data_in,   v.x_m_din);
            chk1 (v.name, "i_done",      i_done,      v.x_i_done);
            chk1 (v.name, "d_done",      d_done,      v.x_d_done);
            chk16(v.name, "i_data_out",  i_data_out,  v.x_i_dout);
            chk16(v.name, "d_data_out",  d_data_out,  v.x_d_dout);
            chk1 (v.name, "i_stall",     i_stall,     v.x_i_stall);
            chk1 (v.name, "d_stall",     d_stall,     v.x_d_stall);
            chk1 (v.name, "i_cache_hit", i_cache_hit, v.x_i_hit);
            chk1 (v.name, "d_cache_hit", d_cache_hit, v.x_d_hit);
            chk1 (v.name, "err",         err,         v.x_err);
            @(posedge clk);
            #1;
        end

        // Continuous contention from reset: round-robin alternates D,I,D,I,
        // fixed priority keeps granting D.
        drive(H, L, Z, L, L, Z, Z, Z, L, L, L);
        @(posedge clk);
        #1;
        for (int t = 0; t < 4; t++) begin
            logic        exp_d;
            logic [15:0] exp_addr;
            exp_d    = (t % 2) == 0;
            exp_addr = exp_d ? 16'h0AAA : 16'h0BBB;
            drive(L, H, 16'h0BBB, H, L, 16'h0AAA, Z, Z, L, L, L);
            #2;
            chk1("contend_idle", "m_rd",       m_rd,   L);
            chk1("contend_idle", "fixed_m_rd", f_m_rd, L);
            @(posedge clk);
            #1;
            m_done     = 1'b1;
            m_data_out = 16'(t + 1);
            #2;
            chk1 ("contend_busy", "m_rd",         m_rd,         H);
            chk16("contend_busy", "m_addr",       m_addr,       exp_addr);
            chk1 ("contend_busy", "d_done",       d_done,       exp_d);
            chk1 ("contend_busy", "i_done",       i_done,       !exp_d);
            chk16("contend_busy", "d_data_out",   d_data_out,   exp_d ? 16'(t + 1) : Z);
            chk16("contend_busy", "fixed_m_addr", f_m_addr,     16'h0AAA);
            chk1 ("contend_busy", "fixed_d_done", f_d_done,     H);
            chk1 ("contend_busy", "fixed_i_done", f_i_done,     L);
            chk1 ("contend_busy", "fixed_i_stall", f_i_stall,   H);
            @(posedge clk);
            #1;
        end

        drive(L, L, Z, L, L, Z, Z, Z, L, L, L);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
